// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer for the 8x16 snake grid: random candidates checked
// against the body occupancy store, with a linear-scan fallback once retries run out.
module food_spawn_ctrl #(
    parameter int MAX_TRIES = 4,
    parameter int TRY_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn_req,
    input  logic [6:0] rand_num,
    output logic       occ_rd,
    output logic [6:0] occ_addr,
    input  logic       occ_hit,
    output logic [3:0] food_x,
    output logic [2:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_done,
    output logic       spawn_fail
);

    localparam logic [TRY_W:0] MAX_T    = MAX_TRIES[TRY_W:0];
    localparam logic [7:0]     SCAN_LEN = 8'd128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [6:0]       mix_cnt;
    logic [6:0]       cand, cand_nx;
    logic [TRY_W-1:0] tries, tries_nx;
    logic [7:0]       scan_cnt, scan_nx;
    logic             occ_rd_nx;
    logic [6:0]       occ_addr_nx;
    logic [3:0]       food_x_nx;
    logic [2:0]       food_y_nx;
    logic             food_valid_nx;
    logic             busy_nx;
    logic             done_nx, fail_nx;

    logic [6:0]       rand_mix;
    logic [TRY_W:0]   tries_inc;
    logic             scanning;

    assign rand_mix  = rand_num ^ mix_cnt;
    assign tries_inc = {1'b0, tries} + 1'b1;
    // scan_cnt is cleared at spawn start and only becomes non-zero in scan mode
    assign scanning  = (scan_cnt != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_cnt <= 7'd0;
        end else begin
            mix_cnt <= mix_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cand       <= 7'd0;
            tries      <= '0;
            scan_cnt   <= 8'd0;
            occ_rd     <= 1'b0;
            occ_addr   <= 7'd0;
            food_x     <= 4'd0;
            food_y     <= 3'd0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
        end else begin
            state      <= state_nx;
            cand       <= cand_nx;
            tries      <= tries_nx;
            scan_cnt   <= scan_nx;
            occ_rd     <= occ_rd_nx;
            occ_addr   <= occ_addr_nx;
            food_x     <= food_x_nx;
            food_y     <= food_y_nx;
            food_valid <= food_valid_nx;
            busy       <= busy_nx;
            spawn_done <= done_nx;
            spawn_fail <= fail_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cand_nx       = cand;
        tries_nx      = tries;
        scan_nx       = scan_cnt;
        occ_rd_nx     = 1'b0;
        occ_addr_nx   = occ_addr;
        food_x_nx     = food_x;
        food_y_nx     = food_y;
        food_valid_nx = food_valid;
        done_nx       = 1'b0;
        fail_nx       = 1'b0;

        case (state)
            S_IDLE: begin
                if (spawn_req) begin
                    cand_nx       = rand_mix;
                    tries_nx      = '0;
                    scan_nx       = 8'd0;
                    food_valid_nx = 1'b0;
                    state_nx      = S_QUERY;
                end
            end
            S_QUERY: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!occ_hit) begin
                    food_x_nx     = cand[3:0];
                    food_y_nx     = cand[6:4];
                    food_valid_nx = 1'b1;
                    done_nx       = 1'b1;
                    state_nx      = S_IDLE;
                end else if (!scanning) begin
                    if (tries_inc < MAX_T) begin
                        tries_nx = tries_inc[TRY_W-1:0];
                        cand_nx  = rand_mix;
                    end else begin
                        // Scan starts one past the last random pick so it ends back on it
                        cand_nx = cand + 7'd1;
                        scan_nx = 8'd1;
                    end
                    state_nx = S_QUERY;
                end else if (scan_cnt < SCAN_LEN) begin
                    cand_nx  = cand + 7'd1;
                    scan_nx  = scan_cnt + 8'd1;
                    state_nx = S_QUERY;
                end else begin
                    fail_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Read strobe and address are registered so they line up with the QUERY state
        if (state_nx == S_QUERY) begin
            occ_rd_nx   = 1'b1;
            occ_addr_nx = cand_nx;
        end
        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl: best case, retry, scan fallback, full grid,
// held request, mid-operation reset.
module tb_food_spawn_ctrl;

    logic       clk;
    logic       rst_n;
    logic       spawn_req;
    logic [6:0] rand_num;
    logic       occ_rd;
    logic [6:0] occ_addr;
    logic       occ_hit;
    logic [3:0] food_x;
    logic [2:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       spawn_done;
    logic       spawn_fail;

    int n_checks = 0;
    int n_fails  = 0;

    logic [6:0] addrs [0:139];
    int         n_reads;
    int         end_cyc;
    logic       got_done, got_fail, overlap;

    food_spawn_ctrl #(.MAX_TRIES(4), .TRY_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spawn_req  (spawn_req),
        .rand_num   (rand_num),
        .occ_rd     (occ_rd),
        .occ_addr   (occ_addr),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .spawn_done (spawn_done),
        .spawn_fail (spawn_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reset, idle 5 cycles (mix counter = 5 at the request edge), then one spawn.
    // Reads 0..n_hits-1 see occupied cells; later reads see free cells.
    task automatic run_spawn(input logic [6:0] rnd, input int n_hits);
        @(negedge clk);
        rst_n     = 1'b0;
        spawn_req = 1'b0;
        occ_hit   = 1'b0;
        rand_num  = rnd;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_reads  = 0;
        end_cyc  = 0;
        got_done = 1'b0;
        got_fail = 1'b0;
        overlap  = 1'b0;
        spawn_req = 1'b1;
        for (int c = 1; c <= 400 && !(got_done || got_fail); c++) begin
            @(negedge clk);
            spawn_req = 1'b0;
            if (spawn_done && spawn_fail) overlap = 1'b1;
            if (occ_rd) begin
                if (n_reads < 140) addrs[n_reads] = occ_addr;
                occ_hit = (n_reads < n_hits);
                n_reads++;
            end
            if (spawn_done || spawn_fail) begin
                got_done = spawn_done;
                got_fail = spawn_fail;
                end_cyc  = c;
            end
        end
        chk_eq("spawn_finished", {31'd0, got_done | got_fail}, 32'd1);
    endtask

    initial begin
        logic [127:0] seen;
        int           distinct;

        rst_n     = 1'b0;
        spawn_req = 1'b0;
        rand_num  = 7'd0;
        occ_hit   = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("reset_outputs",
               {17'd0, occ_rd, occ_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail},
               32'd0);

        // Best case: 7'h20 ^ 5 = 7'h25 -> x=5, y=2
        run_spawn(7'h20, 0);
        chk_eq("best_reads", n_reads, 1);
        chk_eq("best_addr", addrs[0], 7'h25);
        chk_eq("best_latency", end_cyc, 3);
        chk_eq("best_done", got_done, 1'b1);
        chk_eq("best_food_x", food_x, 4'd5);
        chk_eq("best_food_y", food_y, 3'd2);
        chk_eq("best_valid", food_valid, 1'b1);
        chk_eq("best_busy_end", busy, 1'b0);
        @(negedge clk);
        chk_eq("best_done_pulse", spawn_done, 1'b0);
        chk_eq("best_valid_hold", food_valid, 1'b1);

        // One retry: second candidate latched with counter 7 -> 7'h20 ^ 7 = 7'h27
        run_spawn(7'h20, 1);
        chk_eq("retry_reads", n_reads, 2);
        chk_eq("retry_addr0", addrs[0], 7'h25);
        chk_eq("retry_addr1", addrs[1], 7'h27);
        chk_eq("retry_latency", end_cyc, 5);
        chk_eq("retry_food", {food_y, food_x}, 7'h27);
        chk_eq("retry_valid", food_valid, 1'b1);

        // Scan fallback: 7'h74 ^ {5,7,9,11} = 71,73,7D,7F; scan wraps to 0
        run_spawn(7'h74, 4);
        chk_eq("scan_reads", n_reads, 5);
        chk_eq("scan_addr1", addrs[1], 7'h73);
        chk_eq("scan_addr2", addrs[2], 7'h7D);
        chk_eq("scan_last_rand", addrs[3], 7'h7F);
        chk_eq("scan_wrap_addr", addrs[4], 7'h00);
        chk_eq("scan_latency", end_cyc, 11);
        chk_eq("scan_food", {food_y, food_x}, 7'h00);
        chk_eq("scan_done", {got_done, got_fail}, 2'b10);
        chk_eq("scan_valid", food_valid, 1'b1);

        // Full grid: 4 random reads + 128 scan reads, then spawn_fail
        run_spawn(7'h74, 1000);
        chk_eq("full_reads", n_reads, 132);
        chk_eq("full_first_scan", addrs[4], 7'h00);
        chk_eq("full_last_scan", addrs[131], 7'h7F);
        seen = '0;
        for (int i = 4; i < 132; i++) seen[addrs[i]] = 1'b1;
        distinct = 0;
        for (int i = 0; i < 128; i++) if (seen[i]) distinct++;
        chk_eq("full_scan_cover", distinct, 128);
        chk_eq("full_latency", end_cyc, 265);
        chk_eq("full_fail", {got_done, got_fail}, 2'b01);
        chk_eq("full_no_overlap", overlap, 1'b0);
        chk_eq("full_valid", food_valid, 1'b0);
        chk_eq("full_busy_end", busy, 1'b0);
        @(negedge clk);
        chk_eq("full_fail_pulse", spawn_fail, 1'b0);
        chk_eq("full_busy_after", busy, 1'b0);

        // Request held high: one spawn per IDLE visit, then a mid-WAIT reset
        @(negedge clk);
        rst_n     = 1'b0;
        occ_hit   = 1'b0;
        rand_num  = 7'h20;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        chk_eq("hold_query1", {occ_rd, occ_addr}, {1'b1, 7'h25});
        @(negedge clk);
        chk_eq("hold_wait_rd", occ_rd, 1'b0);
        chk_eq("hold_wait_busy", busy, 1'b1);
        @(negedge clk);
        chk_eq("hold_done", spawn_done, 1'b1);
        chk_eq("hold_food", {food_valid, food_y, food_x}, {1'b1, 7'h25});
        @(negedge clk);
        // Restart in IDLE at counter 8: 7'h20 ^ 8 = 7'h28
        chk_eq("hold_query2", {occ_rd, occ_addr}, {1'b1, 7'h28});
        chk_eq("hold_valid_drop", food_valid, 1'b0);
        spawn_req = 1'b0;
        @(negedge clk);
        chk_eq("mid_wait_state", {busy, occ_rd, occ_addr}, {1'b1, 1'b0, 7'h28});
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async_reset_outputs",
               {17'd0, occ_rd, occ_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail},
               32'd0);

        // Spawn after reset behaves as the best case
        run_spawn(7'h20, 0);
        chk_eq("post_reset_addr", addrs[0], 7'h25);
        chk_eq("post_reset_latency", end_cyc, 3);
        chk_eq("post_reset_food", {food_valid, food_y, food_x}, {1'b1, 7'h25});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
